// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipeline datapath and pipe_hazard_ctrl.
// The master side is the datapath and the slave side is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       D_op;
    logic [4:0]       D_rs1;
    logic [4:0]       D_rs2;
    logic [4:0]       E_op;
    logic [4:0]       E_rd;
    logic             jb;
    logic             M_mem_req;
    logic             mem_ready;
    logic             F_stall;
    logic             D_stall;
    logic             D_flush;
    logic             E_flush;
    logic             MW_hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             proto_err;

    modport master (
        output D_op, D_rs1, D_rs2, E_op, E_rd, jb, M_mem_req, mem_ready,
        input  F_stall, D_stall, D_flush, E_flush, MW_hold,
        input  stall_cnt, flush_cnt, proto_err
    );

    modport slave (
        input  D_op, D_rs1, D_rs2, E_op, E_rd, jb, M_mem_req, mem_ready,
        output F_stall, D_stall, D_flush, E_flush, MW_hold,
        output stall_cnt, flush_cnt, proto_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use and redirect
// handling, a memory-wait freeze FSM, saturating counters and a sticky protocol flag.
module pipe_hazard_ctrl #(
    parameter logic [4:0]  LOAD_OP = 5'b00000,
    parameter int unsigned CNT_W   = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             proto_err_q, proto_err_d;

    logic use_rs1_s;
    logic use_rs2_s;
    logic lu_s;
    logic freeze_s;
    logic err_set_s;
    logic f_stall_s;
    logic d_flush_s;
    logic e_flush_s;

    // Source-register usage of the instruction in D, then the load-use compare.
    always_comb begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b0;
        case (hz.D_op)
            OP_LUI, OP_AUIPC, OP_JAL:   use_rs1_s = 1'b0;
            OP_OP, OP_STORE, OP_BRANCH: use_rs2_s = 1'b1;
            default: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b0;
            end
        endcase
        // A bubble in E looks like a LOAD to x0, so rd==0 must never match.
        lu_s = (hz.E_op == LOAD_OP) && (hz.E_rd != 5'd0) &&
               ((use_rs1_s && (hz.D_rs1 == hz.E_rd)) ||
                (use_rs2_s && (hz.D_rs2 == hz.E_rd)));
    end

    // Memory-wait FSM: freeze while an M access is outstanding and unacknowledged.
    always_comb begin
        freeze_s  = 1'b0;
        err_set_s = 1'b0;
        state_d   = state_q;
        case (state_q)
            RUN: begin
                freeze_s = hz.M_mem_req && !hz.mem_ready;
                if (freeze_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                end else if (!hz.M_mem_req) begin
                    // Request withdrawn before acknowledge: flag it and resume.
                    err_set_s = 1'b1;
                    state_d   = RUN;
                end else begin
                    freeze_s = 1'b1;
                    state_d  = WAIT;
                end
            end
            default: begin
                freeze_s  = 1'b0;
                err_set_s = 1'b0;
                state_d   = RUN;
            end
        endcase
    end

    // Control outputs with priority freeze > redirect > load-use.
    always_comb begin
        f_stall_s = freeze_s || (lu_s && !hz.jb);
        d_flush_s = hz.jb && !freeze_s;
        e_flush_s = (hz.jb || lu_s) && !freeze_s;
    end

    // Next values of the saturating counters and the sticky error flag.
    always_comb begin
        if (f_stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (d_flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        proto_err_d = proto_err_q || err_set_s;
    end

    // State, counters and error flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign hz.F_stall   = f_stall_s;
    assign hz.D_stall   = f_stall_s;
    assign hz.D_flush   = d_flush_s;
    assign hz.E_flush   = e_flush_s;
    assign hz.MW_hold   = freeze_s;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.proto_err = proto_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with 4-bit counters so saturation is reachable.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

    pipe_hazard_ctrl #(
        .LOAD_OP(5'b00000),
        .CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed controls in the order {F_stall, D_stall, D_flush, E_flush, MW_hold}.
    function automatic logic [4:0] ctl();
        return {hz.F_stall, hz.D_stall, hz.D_flush, hz.E_flush, hz.MW_hold};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] d_op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] e_op, input logic [4:0] e_rd, input logic jb,
                         input logic req, input logic rdy);
        hz.D_op      = d_op;
        hz.D_rs1     = rs1;
        hz.D_rs2     = rs2;
        hz.E_op      = e_op;
        hz.E_rd      = e_rd;
        hz.jb        = jb;
        hz.M_mem_req = req;
        hz.mem_ready = rdy;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("rst_ctl",   32'(ctl()),           32'(5'b00000));
        chk("rst_stall", 32'(hz.stall_cnt),    32'd0);
        chk("rst_flush", 32'(hz.flush_cnt),    32'd0);
        chk("rst_perr",  32'(hz.proto_err),    32'd0);
        chk("rst_state", 32'(dut.state_q),     32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load-use via rs2 of an OP instruction
        tick();
        drive(5'b01100, 5'd3, 5'd5, 5'b00000, 5'd5, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_ctl", 32'(ctl()), 32'(5'b11010));
        tick();
        chk("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        // Bubble in E: rd==0 never hazards
        drive(5'b01100, 5'd0, 5'd0, 5'b00000, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("bubble_ctl", 32'(ctl()), 32'(5'b00000));
        tick();
        chk("bubble_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        // LUI reads no registers
        drive(5'b01101, 5'd5, 5'd5, 5'b00000, 5'd5, 1'b0, 1'b0, 1'b0);
        #1 chk("lui_ctl", 32'(ctl()), 32'(5'b00000));
        tick();
        // OP-IMM uses rs1 only
        drive(5'b00100, 5'd5, 5'd9, 5'b00000, 5'd5, 1'b0, 1'b0, 1'b0);
        #1 chk("opimm_rs1_ctl", 32'(ctl()), 32'(5'b11010));
        tick();
        chk("opimm_stall_cnt", 32'(hz.stall_cnt), 32'd2);
        drive(5'b00100, 5'd9, 5'd5, 5'b00000, 5'd5, 1'b0, 1'b0, 1'b0);
        #1 chk("opimm_rs2_ctl", 32'(ctl()), 32'(5'b00000));
        tick();
        drive(5'b01000, 5'd9, 5'd5, 5'b00000, 5'd5, 1'b0, 1'b0, 1'b0);
        #1 chk("store_rs2_ctl", 32'(ctl()), 32'(5'b11010));
        tick();
        chk("store_stall_cnt", 32'(hz.stall_cnt), 32'd3);

        // Redirect together with load-use: flush wins, no stall
        drive(5'b01100, 5'd5, 5'd0, 5'b00000, 5'd5, 1'b1, 1'b0, 1'b0);
        #1 chk("jb_lu_ctl", 32'(ctl()), 32'(5'b00110));
        tick();
        chk("jb_flush_cnt1", 32'(hz.flush_cnt), 32'd1);
        chk("jb_ctl_hold",   32'(ctl()),        32'(5'b00110));
        tick();
        chk("jb_flush_cnt2", 32'(hz.flush_cnt), 32'd2);
        chk("jb_stall_cnt",  32'(hz.stall_cnt), 32'd3);

        // Memory wait: 3 unacknowledged cycles with jb held throughout
        drive(5'b01100, 5'd5, 5'd0, 5'b01100, 5'd5, 1'b1, 1'b1, 1'b0);
        #1 chk("mw_c1_ctl",   32'(ctl()),        32'(5'b11001));
        chk("mw_c1_state",    32'(dut.state_q),  32'd0);
        tick();
        chk("mw_c2_ctl",      32'(ctl()),        32'(5'b11001));
        chk("mw_c2_state",    32'(dut.state_q),  32'd1);
        tick();
        chk("mw_c3_ctl",      32'(ctl()),        32'(5'b11001));
        chk("mw_c3_state",    32'(dut.state_q),  32'd1);
        tick();
        hz.mem_ready = 1'b1;
        #1 chk("mw_rel_ctl",  32'(ctl()),        32'(5'b00110));
        tick();
        chk("mw_state_run",   32'(dut.state_q),  32'd0);
        chk("mw_stall_cnt",   32'(hz.stall_cnt), 32'd6);
        chk("mw_flush_cnt",   32'(hz.flush_cnt), 32'd3);

        // Request acknowledged in its first cycle
        drive(5'b01100, 5'd5, 5'd0, 5'b01100, 5'd5, 1'b0, 1'b1, 1'b1);
        #1 chk("ack1_ctl", 32'(ctl()), 32'(5'b00000));
        tick();
        chk("ack1_state",     32'(dut.state_q),  32'd0);
        chk("ack1_stall_cnt", 32'(hz.stall_cnt), 32'd6);

        // Protocol error: request withdrawn while waiting
        hz.mem_ready = 1'b0;
        #1 chk("pe_freeze_ctl", 32'(ctl()), 32'(5'b11001));
        tick();
        chk("pe_wait_state", 32'(dut.state_q), 32'd1);
        hz.M_mem_req = 1'b0;
        #1 chk("pe_drop_ctl", 32'(ctl()), 32'(5'b00000));
        tick();
        chk("pe_flag",       32'(hz.proto_err), 32'd1);
        chk("pe_state_run",  32'(dut.state_q),  32'd0);
        chk("pe_stall_cnt",  32'(hz.stall_cnt), 32'd7);
        hz.M_mem_req = 1'b1;
        tick();
        chk("pe_sticky",     32'(hz.proto_err), 32'd1);
        chk("pe_wait2",      32'(dut.state_q),  32'd1);
        chk("pe_stall_cnt2", 32'(hz.stall_cnt), 32'd8);

        // Asynchronous reset in the middle of WAIT
        #2 rst = 1'b0;
        #1;
        chk("arst_state", 32'(dut.state_q),  32'd0);
        chk("arst_perr",  32'(hz.proto_err), 32'd0);
        chk("arst_stall", 32'(hz.stall_cnt), 32'd0);
        chk("arst_flush", 32'(hz.flush_cnt), 32'd0);
        chk("arst_ctl",   32'(ctl()),        32'(5'b11001));
        hz.M_mem_req = 1'b0;
        #1 rst = 1'b1;

        // Saturation of stall_cnt under a held load-use stall
        drive(5'b01100, 5'd5, 5'd0, 5'b00000, 5'd5, 1'b0, 1'b0, 1'b0);
        repeat (14) tick();
        chk("sat_stall_14", 32'(hz.stall_cnt), 32'd14);
        tick();
        chk("sat_stall_15", 32'(hz.stall_cnt), 32'd15);
        repeat (5) tick();
        chk("sat_stall_stick", 32'(hz.stall_cnt), 32'd15);

        // Saturation of flush_cnt under a held redirect
        hz.jb = 1'b1;
        repeat (18) tick();
        chk("sat_flush_stick", 32'(hz.flush_cnt), 32'd15);
        chk("sat_stall_final", 32'(hz.stall_cnt), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
